// File: rtl/uart_fifo_ctrl.sv
// Buffered CPU front-end for the 8-bit uart: a polling FSM drains RX bytes into a FIFO and feeds TX bytes from another.
// Optional IRQ enable register and interrupt output are built when UART_FIFO_CTRL_IRQ_EN is defined.
module uart_fifo_ctrl #(
    parameter int DEPTH_LOG2  = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_we,
    input  logic       i_cyc,
    output logic       o_u_addr,
    output logic [7:0] o_u_dat,
    input  logic [7:0] i_u_dat,
    output logic       o_u_we,
    output logic       o_u_cyc,
    output logic       o_irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_POLL, ST_RXRD, ST_TXWR, ST_HOLD} state_t;

    state_t state_reg, state_next;
    logic [HW-1:0] hold_cnt_reg;

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [DEPTH_LOG2:0]   tx_count_reg, rx_count_reg;

    logic rx_full_sticky_reg, overrun_sticky_reg, tx_idle_reg;

    logic host_wr, host_rd;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_done;
    logic [7:0] status;
    logic [7:0] irq_en_rd;

    assign host_wr  = i_cyc & i_we;
    assign host_rd  = i_cyc & ~i_we;
    assign tx_full  = (tx_count_reg == FULL_COUNT);
    assign tx_empty = (tx_count_reg == '0);
    assign rx_full  = (rx_count_reg == FULL_COUNT);
    assign rx_empty = (rx_count_reg == '0);
    assign tx_done  = tx_idle_reg & tx_empty;

    // Fullness uses the start-of-cycle count, so a push into a full FIFO is dropped even if the FSM pops now.
    assign tx_push = host_wr & (i_addr == 2'd0) & ~tx_full;
    assign tx_pop  = (state_reg == ST_TXWR);
    assign rx_push = (state_reg == ST_RXRD);
    assign rx_pop  = host_rd & (i_addr == 2'd0) & ~rx_empty;

    assign status = {3'b000, overrun_sticky_reg, tx_done, rx_full_sticky_reg, tx_full, ~rx_empty};

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= ST_POLL;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= (state_reg == ST_HOLD) ? hold_cnt_reg + 1'b1 : '0;
        end
    end

    // FSM next state; RX draining always wins over transmit
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_POLL: begin
                if (i_u_dat[0] && !rx_full)
                    state_next = ST_RXRD;
                else if (!i_u_dat[2] && !tx_empty)
                    state_next = ST_TXWR;
                else
                    state_next = ST_POLL;
            end
            ST_RXRD: state_next = ST_POLL;
            ST_TXWR: state_next = (HOLD_CYCLES == 0) ? ST_POLL : ST_HOLD;
            ST_HOLD: begin
                if (hold_cnt_reg == HW'(HOLD_CYCLES - 1))
                    state_next = ST_POLL;
            end
            default: state_next = ST_POLL;
        endcase
    end

    // FSM outputs; reset drops any strobe immediately
    always_comb begin
        o_u_cyc  = 1'b0;
        o_u_addr = 1'b0;
        o_u_we   = 1'b0;
        o_u_dat  = 8'h00;
        if (!i_reset) begin
            case (state_reg)
                ST_POLL: begin
                    o_u_cyc  = 1'b1;
                    o_u_addr = 1'b1;
                end
                ST_RXRD: o_u_cyc = 1'b1;
                ST_TXWR: begin
                    o_u_cyc = 1'b1;
                    o_u_we  = 1'b1;
                    o_u_dat = tx_mem[tx_rd_ptr_reg];
                end
                default: o_u_cyc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg] <= i_dat;
        if (rx_push)
            rx_mem[rx_wr_ptr_reg] <= i_u_dat;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            if (tx_push && !tx_pop)
                tx_count_reg <= tx_count_reg + 1'b1;
            else if (!tx_push && tx_pop)
                tx_count_reg <= tx_count_reg - 1'b1;

            if (rx_push)
                rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)
                rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            if (rx_push && !rx_pop)
                rx_count_reg <= rx_count_reg + 1'b1;
            else if (!rx_push && rx_pop)
                rx_count_reg <= rx_count_reg - 1'b1;
        end
    end

    // Stickies: a fresh POLL observation takes precedence over a host clear in the same cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_full_sticky_reg <= 1'b0;
            overrun_sticky_reg <= 1'b0;
            tx_idle_reg        <= 1'b1;
        end else begin
            if (host_wr && i_addr == 2'd1) begin
                if (i_dat[2])
                    rx_full_sticky_reg <= 1'b0;
                if (i_dat[4])
                    overrun_sticky_reg <= 1'b0;
            end
            if (state_reg == ST_POLL) begin
                tx_idle_reg <= ~i_u_dat[2];
                if (i_u_dat[1])
                    overrun_sticky_reg <= 1'b1;
                if (i_u_dat[0] && rx_full)
                    rx_full_sticky_reg <= 1'b1;
            end
        end
    end

`ifdef UART_FIFO_CTRL_IRQ_EN
    logic [2:0] irq_en_reg;
    logic       irq_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            irq_en_reg <= 3'b000;
            irq_reg    <= 1'b0;
        end else begin
            if (host_wr && i_addr == 2'd2)
                irq_en_reg <= i_dat[2:0];
            irq_reg <= |(irq_en_reg & {rx_full_sticky_reg | overrun_sticky_reg, tx_done, ~rx_empty});
        end
    end

    assign irq_en_rd = {5'b00000, irq_en_reg};
    assign o_irq     = irq_reg;
`else
    assign irq_en_rd = 8'h00;
    assign o_irq     = 1'b0;
`endif

    always_comb begin
        o_dat = 8'h00;
        case (i_addr)
            2'd0:    o_dat = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
            2'd1:    o_dat = status;
            2'd2:    o_dat = irq_en_rd;
            default: o_dat = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl with a behavioural uart register model.
// Exercises the IRQ register when UART_FIFO_CTRL_IRQ_EN is defined.
module tb_uart_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] i_addr;
    logic [7:0] i_dat;
    logic [7:0] o_dat;
    logic       i_we, i_cyc;
    logic       u_addr, u_we, u_cyc;
    logic [7:0] u_wdat, u_rdat;
    logic       irq;

    int checks = 0;
    int errors = 0;

    // uart model state
    int         cyc = 0;
    int         busy_cnt = 0;
    bit         hold_busy = 1'b0;
    bit         ovr = 1'b0;
    int         rx_total = 0;
    int         rx_taken = 0;
    logic [7:0] rx_base = 8'h00;
    logic [7:0] rx_next;
    logic [7:0] tx_log [0:63];
    int         tx_cyc_log [0:63];
    int         tx_n = 0;
    int         tx_busy_err = 0;
    int         rxrd_n = 0;

    uart_fifo_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_addr(i_addr), .i_dat(i_dat), .o_dat(o_dat),
        .i_we(i_we), .i_cyc(i_cyc), .o_u_addr(u_addr), .o_u_dat(u_wdat),
        .i_u_dat(u_rdat), .o_u_we(u_we), .o_u_cyc(u_cyc), .o_irq(irq)
    );

    always #5 clk = ~clk;

    assign rx_next = rx_base + rx_taken[7:0];
    assign u_rdat  = u_addr ? {5'b00000, (busy_cnt != 0) || hold_busy, ovr, rx_total > rx_taken}
                            : rx_next;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
        if (u_cyc && !u_addr && u_we) begin
            if (busy_cnt != 0 || hold_busy)
                tx_busy_err <= tx_busy_err + 1;
            if (tx_n < 64) begin
                tx_log[tx_n]     <= u_wdat;
                tx_cyc_log[tx_n] <= cyc;
                tx_n             <= tx_n + 1;
            end
            busy_cnt <= 6;
        end
        if (u_cyc && !u_addr && !u_we) begin
            rxrd_n <= rxrd_n + 1;
            if (rx_total > rx_taken)
                rx_taken <= rx_taken + 1;
        end
    end

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        i_addr = a; i_dat = d; i_we = 1'b1; i_cyc = 1'b1;
        @(posedge clk); #1;
        i_cyc = 1'b0; i_we = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] a, output logic [7:0] d);
        i_addr = a; i_we = 1'b0; i_cyc = 1'b1;
        @(negedge clk);
        d = o_dat;
        @(posedge clk); #1;
        i_cyc = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_cyc = 1'b0; i_we = 1'b0; i_addr = 2'd1; i_dat = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_dat !== 8'h08) begin errors++; $display("FAIL reset_status got %h exp 08", o_dat); end
        checks++;
        if ({u_cyc, u_we, u_addr, u_wdat, irq} !== 12'h000) begin
            errors++; $display("FAIL reset_outputs got %h exp 000", {u_cyc, u_we, u_addr, u_wdat, irq});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({u_cyc, u_addr, u_we} !== 3'b110) begin
            errors++; $display("FAIL first_poll got %b exp 110", {u_cyc, u_addr, u_we});
        end
        wait_cycles(1);
    endtask

    task automatic test_tx_pair;
        int base, n0, t;
        base = tx_n;
        n0 = cyc;
        host_wr(2'd0, 8'h41);
        host_wr(2'd0, 8'h42);
        t = 0;
        while (tx_n < base + 2 && t < 200) begin wait_cycles(1); t++; end
        checks++;
        if (tx_n !== base + 2) begin errors++; $display("FAIL tx_pair_count got %0d exp %0d", tx_n - base, 2); end
        else begin
            checks++;
            if (tx_log[base] !== 8'h41 || tx_log[base+1] !== 8'h42) begin
                errors++; $display("FAIL tx_pair_order got %h %h exp 41 42", tx_log[base], tx_log[base+1]);
            end
            checks++;
            if (tx_cyc_log[base] - n0 > 3) begin
                errors++; $display("FAIL tx_latency got %0d exp <=3", tx_cyc_log[base] - n0);
            end
            checks++;
            if (tx_cyc_log[base+1] - tx_cyc_log[base] < 4) begin
                errors++; $display("FAIL tx_spacing got %0d exp >=4", tx_cyc_log[base+1] - tx_cyc_log[base]);
            end
        end
        checks++;
        if (tx_busy_err !== 0) begin errors++; $display("FAIL tx_while_busy got %0d exp 0", tx_busy_err); end
        wait_cycles(12);
    endtask

    task automatic test_tx_full;
        int base, t;
        logic [7:0] d;
        hold_busy = 1'b1;
        wait_cycles(2);
        base = tx_n;
        for (int i = 0; i < 16; i++) host_wr(2'd0, 8'h10 + 8'(i));
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL tx_full_status got %h exp 02", d); end
        host_wr(2'd0, 8'hEE);
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL tx_full_after_drop got %h exp 02", d); end
        checks++;
        if (tx_n !== base) begin errors++; $display("FAIL tx_sent_while_busy got %0d exp 0", tx_n - base); end
        hold_busy = 1'b0;
        t = 0;
        while (tx_n < base + 16 && t < 600) begin wait_cycles(1); t++; end
        wait_cycles(40);
        checks++;
        if (tx_n !== base + 16) begin errors++; $display("FAIL tx_full_count got %0d exp 16", tx_n - base); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_log[base+i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL tx_wrap_data[%0d] got %h exp %h", i, tx_log[base+i], 8'h10 + 8'(i));
            end
        end
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h08) begin errors++; $display("FAIL tx_drained_status got %h exp 08", d); end
        checks++;
        if (tx_busy_err !== 0) begin errors++; $display("FAIL tx_while_busy got %0d exp 0", tx_busy_err); end
    endtask

    task automatic test_rx_single;
        logic [7:0] d;
        rx_base  = 8'h5A - rx_taken[7:0];
        rx_total = rx_taken + 1;
        wait_cycles(5);
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h09) begin errors++; $display("FAIL rx_status_avail got %h exp 09", d); end
        host_rd(2'd0, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL rx_pop got %h exp 5A", d); end
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h08) begin errors++; $display("FAIL rx_status_empty got %h exp 08", d); end
        host_rd(2'd0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rx_empty_pop got %h exp 00", d); end
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h08) begin errors++; $display("FAIL rx_empty_pop_status got %h exp 08", d); end
    endtask

    task automatic test_rx_full;
        int r0;
        logic [7:0] d;
        r0 = rxrd_n;
        rx_base  = 8'h80 - rx_taken[7:0];
        rx_total = rx_taken + 17;
        wait_cycles(60);
        checks++;
        if (rxrd_n - r0 !== 16) begin errors++; $display("FAIL rx_fill_reads got %0d exp 16", rxrd_n - r0); end
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h0D) begin errors++; $display("FAIL rx_full_status got %h exp 0D", d); end
        wait_cycles(10);
        checks++;
        if (rxrd_n - r0 !== 16) begin errors++; $display("FAIL rx_no_read_when_full got %0d exp 16", rxrd_n - r0); end
        host_rd(2'd0, d);
        checks++;
        if (d !== 8'h80) begin errors++; $display("FAIL rx_full_pop got %h exp 80", d); end
        wait_cycles(6);
        checks++;
        if (rxrd_n - r0 !== 17) begin errors++; $display("FAIL rx_read_after_pop got %0d exp 17", rxrd_n - r0); end
        host_wr(2'd1, 8'h04);
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h09) begin errors++; $display("FAIL rx_sticky_clear got %h exp 09", d); end
        for (int i = 1; i <= 16; i++) begin
            host_rd(2'd0, d);
            checks++;
            if (d !== 8'h80 + 8'(i)) begin errors++; $display("FAIL rx_drain[%0d] got %h exp %h", i, d, 8'h80 + 8'(i)); end
        end
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h08) begin errors++; $display("FAIL rx_drained_status got %h exp 08", d); end
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        ovr = 1'b1;
        wait_cycles(3);
        ovr = 1'b0;
        wait_cycles(2);
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h18) begin errors++; $display("FAIL overrun_status got %h exp 18", d); end
        host_wr(2'd1, 8'h10);
        host_rd(2'd1, d);
        checks++;
        if (d !== 8'h08) begin errors++; $display("FAIL overrun_clear got %h exp 08", d); end
        host_wr(2'd3, 8'hFF);
        host_rd(2'd3, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reg3_read got %h exp 00", d); end
    endtask

    task automatic test_irq;
        logic [7:0] d;
`ifdef UART_FIFO_CTRL_IRQ_EN
        host_wr(2'd2, 8'h01);
        host_rd(2'd2, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL irq_en_read got %h exp 01", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
        rx_base  = 8'h33 - rx_taken[7:0];
        rx_total = rx_taken + 1;
        wait_cycles(6);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx_raise got %b exp 1", irq); end
        host_rd(2'd0, d);
        checks++;
        if (d !== 8'h33) begin errors++; $display("FAIL irq_rx_pop got %h exp 33", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_pop_edge got %b exp 1", irq); end
        wait_cycles(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_lower got %b exp 0", irq); end
`else
        rx_base  = 8'h33 - rx_taken[7:0];
        rx_total = rx_taken + 1;
        wait_cycles(6);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied got %b exp 0", irq); end
        host_wr(2'd2, 8'hFF);
        host_rd(2'd2, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reg2_read got %h exp 00", d); end
        host_rd(2'd0, d);
        checks++;
        if (d !== 8'h33) begin errors++; $display("FAIL irq_rx_pop got %h exp 33", d); end
`endif
    endtask

    initial begin
        test_reset;
        test_tx_pair;
        test_tx_full;
        test_rx_single;
        test_rx_full;
        test_overrun;
        test_irq;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
